// File: rtl/intr_arbiter.sv
// -----------------------------------------------------------------------------
// intr_arbiter
//
// Multi-source interrupt controller placed in front of the CPU's single
// INT/Inta pair. Rising edges on the device request lines are latched as
// pending. Pending sources are masked and prioritised, and a single registered
// interrupt request is raised to the CPU. On acknowledge, the winning source
// number is captured in `vector`. Further requests are held off until software
// writes end-of-interrupt (EOI).
//
// Optional build macro:
//   INTR_RR_EN  - round-robin priority using a rotating pointer (last granted
//                 index + 1). When undefined, the lowest index wins and no
//                 pointer register exists.
//
// Parameters:
//   N_SRC  number of sources (2..32)
//   VW     vector width, clog2(N_SRC)
//
// Ports:
//   clk     system clock, rising edge
//   clrn    asynchronous active-low reset
//   irq     device request lines; a 0->1 transition posts a request
//   int_o   registered interrupt request to the CPU
//   inta    CPU acknowledge, one-cycle pulse
//   vector  registered number of the source in service
//   sel     register bank select
//   we      write strobe, qualified by sel
//   addr    word address: 0 MASK, 1 PENDING (W1C), 2 STATUS, 3 EOI
//   wdata   write data
//   rdata   combinational read data
// -----------------------------------------------------------------------------
module intr_arbiter #(
    parameter int N_SRC = 8,
    parameter int VW    = 3
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [N_SRC-1:0] irq,
    output logic             int_o,
    input  logic             inta,
    output logic [VW-1:0]    vector,
    input  logic             sel,
    input  logic             we,
    input  logic [1:0]       addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_REQ     = 2'b01,
        S_SERVICE = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [N_SRC-1:0]   mask_q, mask_d;
    logic [N_SRC-1:0]   pend_q, pend_d;
    logic [N_SRC-1:0]   irq_q;
    logic               in_svc_q, in_svc_d;
    logic               int_q, int_d;
    logic [VW-1:0]      vec_q, vec_d;

    logic               wr_mask, wr_pend, wr_eoi;
    logic [N_SRC-1:0]   edges, enabled, w1c, grant_clr;
    logic               any_en;
    logic [VW-1:0]      winner;

    // Only the low N_SRC bits of wdata are meaningful.
    logic               unused_wdata;
    assign unused_wdata = ^wdata;

    assign wr_mask = sel && we && (addr == 2'd0);
    assign wr_pend = sel && we && (addr == 2'd1);
    assign wr_eoi  = sel && we && (addr == 2'd3);

    assign edges   = irq & ~irq_q;
    assign enabled = pend_q & mask_q;
    assign any_en  = |enabled;
    assign w1c     = wr_pend ? wdata[N_SRC-1:0] : '0;

`ifdef INTR_RR_EN
    logic [VW-1:0] rr_ptr_q, rr_ptr_d;
    int            rr_idx;
    logic          rr_found;

    // Search starts at the pointer and wraps back to index 0.
    always_comb begin
        winner   = '0;
        rr_found = 1'b0;
        rr_idx   = 0;
        for (int k = 0; k < N_SRC; k++) begin
            rr_idx = (int'(rr_ptr_q) + k) % N_SRC;
            if (!rr_found && enabled[rr_idx]) begin
                winner   = VW'(rr_idx);
                rr_found = 1'b1;
            end
        end
    end
`else
    // Descending scan so the lowest set index is the last one assigned.
    always_comb begin
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (enabled[i]) begin
                winner = VW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        int_d     = int_q;
        vec_d     = vec_q;
        in_svc_d  = in_svc_q;
        grant_clr = '0;
`ifdef INTR_RR_EN
        rr_ptr_d  = rr_ptr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (any_en) begin
                    state_d = S_REQ;
                    int_d   = 1'b1;
                end
            end
            S_REQ: begin
                // A grant needs a live winner; with nothing enabled the
                // request is withdrawn and a late acknowledge is ignored.
                if (inta && any_en) begin
                    state_d           = S_SERVICE;
                    int_d             = 1'b0;
                    vec_d             = winner;
                    in_svc_d          = 1'b1;
                    grant_clr[winner] = 1'b1;
`ifdef INTR_RR_EN
                    rr_ptr_d = VW'((int'(winner) + 1) % N_SRC);
`endif
                end else if (!any_en) begin
                    state_d = S_IDLE;
                    int_d   = 1'b0;
                end
            end
            S_SERVICE: begin
                if (wr_eoi) begin
                    state_d  = S_IDLE;
                    in_svc_d = 1'b0;
                    vec_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                int_d   = 1'b0;
            end
        endcase
    end

    // New edges are OR'd in last so they survive both a W1C write and a
    // grant-clear on the same bit in the same cycle.
    assign pend_d = (pend_q & ~w1c & ~grant_clr) | edges;
    assign mask_d = wr_mask ? wdata[N_SRC-1:0] : mask_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q  <= S_IDLE;
            mask_q   <= '0;
            pend_q   <= '0;
            irq_q    <= '0;
            in_svc_q <= 1'b0;
            int_q    <= 1'b0;
            vec_q    <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            pend_q   <= pend_d;
            irq_q    <= irq;
            in_svc_q <= in_svc_d;
            int_q    <= int_d;
            vec_q    <= vec_d;
        end
    end

`ifdef INTR_RR_EN
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign int_o  = int_q;
    assign vector = vec_q;

    always_comb begin
        rdata = '0;
        case (addr)
            2'd0: rdata[N_SRC-1:0] = mask_q;
            2'd1: rdata[N_SRC-1:0] = pend_q;
            2'd2: begin
                rdata[31]     = in_svc_q;
                rdata[9:8]    = state_q;
                rdata[VW-1:0] = vec_q;
            end
            default: rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_intr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_intr_arbiter
//
// Directed scenarios followed by a randomized phase. Every cycle, the DUT is
// compared against a behavioural model of the controller. The model is kept as
// plain integers and bit vectors and updated from the register-map and
// arbitration rules.
// -----------------------------------------------------------------------------
module tb_intr_arbiter;

    localparam int N  = 8;
    localparam int VW = 3;

    logic          clk = 1'b0;
    logic          clrn;
    logic [N-1:0]  irq;
    logic          int_o;
    logic          inta;
    logic [VW-1:0] vector;
    logic          sel;
    logic          we;
    logic [1:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    int vectors     = 0;
    int miscompares = 0;

    intr_arbiter #(.N_SRC(N), .VW(VW)) dut (
        .clk    (clk),
        .clrn   (clrn),
        .irq    (irq),
        .int_o  (int_o),
        .inta   (inta),
        .vector (vector),
        .sel    (sel),
        .we     (we),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [N-1:0] m_mask, m_pend, m_irqq;
    int           m_state;   // 0 idle, 1 requesting, 2 in service
    logic         m_insvc, m_int;
    int           m_vec;
    int           m_ptr;

    function automatic int pick(input logic [N-1:0] en, input int start);
        for (int k = 0; k < N; k++) begin
            if (en[(start + k) % N]) return (start + k) % N;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_mask = '0; m_pend = '0; m_irqq = '0;
        m_state = 0; m_insvc = 1'b0; m_int = 1'b0; m_vec = 0; m_ptr = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] edges, en, clr, w1c;
        logic         wr;
        int           v;
        if (!clrn) begin
            model_reset();
            return;
        end
        wr    = sel && we;
        edges = irq & ~m_irqq;
        en    = m_pend & m_mask;
        clr   = '0;
        case (m_state)
            0: if (en != '0) begin m_state = 1; m_int = 1'b1; end
            1: begin
                if (inta && en != '0) begin
`ifdef INTR_RR_EN
                    v = pick(en, m_ptr);
`else
                    v = pick(en, 0);
`endif
                    clr[v]  = 1'b1;
                    m_vec   = v;
                    m_insvc = 1'b1;
                    m_int   = 1'b0;
                    m_state = 2;
                    m_ptr   = (v + 1) % N;
                end else if (en == '0) begin
                    m_state = 0;
                    m_int   = 1'b0;
                end
            end
            default: if (wr && addr == 2'd3) begin
                m_state = 0; m_insvc = 1'b0; m_vec = 0;
            end
        endcase
        w1c    = (wr && addr == 2'd1) ? wdata[N-1:0] : '0;
        m_pend = (m_pend & ~w1c & ~clr) | edges;
        if (wr && addr == 2'd0) m_mask = wdata[N-1:0];
        m_irqq = irq;
    endtask

    function automatic logic [31:0] model_read(input logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0: r[N-1:0] = m_mask;
            2'd1: r[N-1:0] = m_pend;
            2'd2: begin
                r[31]     = m_insvc;
                r[9:8]    = 2'(m_state);
                r[VW-1:0] = VW'(m_vec);
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("int_o_model", {31'b0, int_o}, {31'b0, m_int});
        check("vector_model", 32'(vector), 32'(m_vec));
        check("rdata_model", rdata, model_read(addr));
        sel  = 1'b0;
        we   = 1'b0;
        inta = 1'b0;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
        sel = 1'b1; we = 1'b1; addr = a; wdata = d;
        tick();
    endtask

    task automatic rd_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    task automatic eoi();
        wr_reg(2'd3, 32'h0);
    endtask

    task automatic do_reset();
        clrn = 1'b0;
        model_reset();
        #1;
        check("rst_int_o", {31'b0, int_o}, 32'd0);
        check("rst_vector", 32'(vector), 32'd0);
        tick();
        clrn = 1'b1;
    endtask

    // Wait (bounded) for a request, acknowledge it, check the granted source.
    task automatic grant(input string tag, input int exp_vec);
        int n;
        n = 0;
        while (int_o !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        check({tag, "_req"}, {31'b0, int_o}, 32'd1);
        inta = 1'b1;
        tick();
        check({tag, "_vec"}, 32'(vector), 32'(exp_vec));
        check({tag, "_int"}, {31'b0, int_o}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn = 1'b0; irq = '0; inta = 1'b0; sel = 1'b0; we = 1'b0;
        addr = 2'd0; wdata = 32'h0;
        model_reset();
        repeat (2) tick();
        rd_check("rst_mask", 2'd0, 32'h0);
        rd_check("rst_pend", 2'd1, 32'h0);
        rd_check("rst_status", 2'd2, 32'h0);
        clrn = 1'b1;
        tick();

        // Reset while a request is outstanding.
        wr_reg(2'd0, 32'hFF);
        irq = 8'h08; tick();
        irq = 8'h00; tick();
        check("t1_int_high", {31'b0, int_o}, 32'd1);
        do_reset();
        tick();
        rd_check("t1_mask", 2'd0, 32'h0);
        rd_check("t1_pend", 2'd1, 32'h0);
        rd_check("t1_status", 2'd2, 32'h0);

        // Basic grant: two-cycle request latency.
        wr_reg(2'd0, 32'h08);
        irq = 8'h08; tick();
        check("t2_int_k", {31'b0, int_o}, 32'd0);
        rd_check("t2_pend_set", 2'd1, 32'h08);
        irq = 8'h00; tick();
        check("t2_int_k1", {31'b0, int_o}, 32'd1);
        inta = 1'b1; tick();
        check("t2_vec", 32'(vector), 32'd3);
        check("t2_int_drop", {31'b0, int_o}, 32'd0);
        rd_check("t2_pend_clr", 2'd1, 32'h0);
        rd_check("t2_status_svc", 2'd2, 32'h8000_0203);
        eoi();
        rd_check("t2_status_eoi", 2'd2, 32'h0);

        // Priority, then repeated posting (round-robin vs fixed).
        do_reset();
        wr_reg(2'd0, 32'hFF);
        irq = 8'h24; tick();
        irq = 8'h00;
        grant("t3a", 2);
        rd_check("t3a_pend", 2'd1, 32'h20);
        eoi();
        check("t3_int_n", {31'b0, int_o}, 32'd0);
        tick();
        check("t3_int_n1", {31'b0, int_o}, 32'd1);
        grant("t3b", 5);
        eoi();
        irq = 8'h24; tick();
        irq = 8'h00;
        grant("t3c", 2);
        irq = 8'h04; tick();
        irq = 8'h00;
        eoi();
`ifdef INTR_RR_EN
        grant("t3d", 5);
        eoi();
        grant("t3e", 2);
`else
        grant("t3d", 2);
        eoi();
        grant("t3e", 5);
`endif
        eoi();

        // Masking.
        wr_reg(2'd0, 32'h00);
        irq = 8'h02; tick();
        irq = 8'h00; tick();
        rd_check("t4_pend", 2'd1, 32'h02);
        check("t4_int_masked", {31'b0, int_o}, 32'd0);
        wr_reg(2'd0, 32'h02);
        check("t4_int_w", {31'b0, int_o}, 32'd0);
        tick();
        check("t4_int_w1", {31'b0, int_o}, 32'd1);
        grant("t4", 1);
        eoi();

        // Withdraw by clearing the only pending source.
        wr_reg(2'd0, 32'h10);
        irq = 8'h10; tick();
        irq = 8'h00; tick();
        check("t5_int", {31'b0, int_o}, 32'd1);
        wr_reg(2'd1, 32'h10);
        tick();
        check("t5_int_drop", {31'b0, int_o}, 32'd0);
        rd_check("t5_status", 2'd2, 32'h0);
        inta = 1'b1; tick();
        check("t5_late_inta_int", {31'b0, int_o}, 32'd0);
        check("t5_late_inta_vec", 32'(vector), 32'd0);
        rd_check("t5_status2", 2'd2, 32'h0);

        // New edge coinciding with the grant-clear of the same bit.
        wr_reg(2'd0, 32'h01);
        irq = 8'h01; tick();
        irq = 8'h00; tick();
        check("t6_int", {31'b0, int_o}, 32'd1);
        irq = 8'h01; inta = 1'b1; tick();
        check("t6_vec", 32'(vector), 32'd0);
        rd_check("t6_pend_kept", 2'd1, 32'h01);
        irq = 8'h00;
        eoi();
        check("t6_int_n", {31'b0, int_o}, 32'd0);
        tick();
        check("t6_int_n1", {31'b0, int_o}, 32'd1);
        grant("t6b", 0);
        eoi();

        // Randomized traffic against the model.
        for (int it = 0; it < 600; it++) begin
            if ($urandom_range(0, 3) == 0) irq = N'($urandom);
            inta  = ($urandom_range(0, 3) == 0);
            sel   = ($urandom_range(0, 4) == 0);
            we    = ($urandom_range(0, 2) != 0);
            addr  = 2'($urandom);
            wdata = ($urandom_range(0, 1) == 0) ? $urandom : 32'hFF;
            if ($urandom_range(0, 149) == 0) begin
                clrn = 1'b0;
                model_reset();
            end else begin
                clrn = 1'b1;
            end
            tick();
        end
        clrn = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
